// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioning slice:
// debounce state encoding and the default debounce interval.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_t;

  // 20 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One pushbutton channel: two-flop synchronizer, debounce FSM with stability
// counter, registered debounced level and one-cycle press pulse.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse,
  output logic accept
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Same-edge strobe so the parent can toggle in step with the registered pulse
  assign accept = (state == PRESS_CHK) && s2 && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (s2) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            state <= RELEASED;
          end else if (cnt == LAST) begin
            state <= HELD;
            level <= 1'b1;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          if (s2) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state <= RELEASED;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the direction and speed pushbuttons into toggled mode levels
// (control, hz) for the up/down LED counter.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_dir,
  input  logic btn_speed,
  output logic control,
  output logic hz,
  output logic dir_pulse,
  output logic speed_pulse,
  output logic dir_level,
  output logic speed_level
);

  logic dir_accept;
  logic speed_accept;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_dir (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_dir),
    .level (dir_level),
    .pulse (dir_pulse),
    .accept(dir_accept)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_speed (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_speed),
    .level (speed_level),
    .pulse (speed_pulse),
    .accept(speed_accept)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      control <= 1'b0;
      hz      <= 1'b0;
    end else begin
      if (dir_accept)   control <= ~control;
      if (speed_accept) hz      <= ~hz;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner with a run-length
// reference model and a pulse scoreboard.
module tb_button_conditioner;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_dir = 1'b0;
  logic btn_speed = 1'b0;
  logic control, hz, dir_pulse, speed_pulse, dir_level, speed_level;

  int tests = 0;
  int failed = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_dir    (btn_dir),
    .btn_speed  (btn_speed),
    .control    (control),
    .hz         (hz),
    .dir_pulse  (dir_pulse),
    .speed_pulse(speed_pulse),
    .dir_level  (dir_level),
    .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronized sample stream lags the pins by two
  // edges; a level flips once D+1 consecutive samples disagree with it.
  bit [1:0] raw_now, raw_d1, raw_d2;
  int       run [2];
  bit       lvl [2];
  bit       pls [2];
  bit       tog [2];
  bit       dir_q[$];
  bit       speed_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_d1 = '0;
      raw_d2 = '0;
      for (int i = 0; i < 2; i++) begin
        run[i] = 0; lvl[i] = 0; pls[i] = 0; tog[i] = 0;
      end
      dir_q.delete();
      speed_q.delete();
    end else begin
      raw_now = {btn_speed, btn_dir};
      for (int i = 0; i < 2; i++) begin
        pls[i] = 0;
        if (raw_d2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == int'(D) + 1) begin
            run[i] = 0;
            lvl[i] = ~lvl[i];
            if (lvl[i]) begin
              pls[i] = 1;
              tog[i] = ~tog[i];
              if (i == 0) dir_q.push_back(tog[0]);
              else        speed_q.push_back(tog[1]);
            end
          end
        end else begin
          run[i] = 0;
        end
      end
      raw_d2 = raw_d1;
      raw_d1 = raw_now;
    end
  end

  // Monitor: per-cycle level/mode comparison plus scoreboard on each pulse
  always @(negedge clk) begin
    chk("dir_level", dir_level, lvl[0]);
    chk("speed_level", speed_level, lvl[1]);
    chk("dir_pulse", dir_pulse, pls[0]);
    chk("speed_pulse", speed_pulse, pls[1]);
    chk("control", control, tog[0]);
    chk("hz", hz, tog[1]);
    if (dir_pulse) begin
      if (dir_q.size() == 0) chk("dir_sb_extra", 1'b1, 1'b0);
      else chk("dir_sb_control", control, dir_q.pop_front());
    end else if (dir_q.size() != 0) begin
      chk("dir_sb_missing", 1'b0, 1'b1);
      dir_q.delete();
    end
    if (speed_pulse) begin
      if (speed_q.size() == 0) chk("speed_sb_extra", 1'b1, 1'b0);
      else chk("speed_sb_hz", hz, speed_q.pop_front());
    end else if (speed_q.size() != 0) begin
      chk("speed_sb_missing", 1'b0, 1'b1);
      speed_q.delete();
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with btn_dir freshly high and its channel idle
  task automatic latency_check(input string name);
    for (int k = 1; k <= int'(D) + 2; k++) begin
      @(negedge clk);
      chk(name, dir_pulse, 1'b0);
    end
    @(negedge clk);
    chk(name, dir_pulse, 1'b1);
  endtask

  task automatic all_zero(input string name);
    chk(name, control, 1'b0);
    chk(name, hz, 1'b0);
    chk(name, dir_pulse, 1'b0);
    chk(name, speed_pulse, 1'b0);
    chk(name, dir_level, 1'b0);
    chk(name, speed_level, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with toggling buttons
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      btn_dir   = 1'($urandom);
      btn_speed = 1'($urandom);
      all_zero("reset_hold");
    end
    btn_dir = 1'b0; btn_speed = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(4);
    all_zero("after_reset");

    // 2: clean dir press with explicit latency
    btn_dir = 1'b1;
    latency_check("dir_latency");
    cycles(5);
    btn_dir = 1'b0;
    cycles(10);

    // 3: speed bounce (3 high, 1 low, 4 high) then a real hold
    btn_speed = 1'b1; cycles(3);
    btn_speed = 1'b0; cycles(1);
    btn_speed = 1'b1; cycles(4);
    btn_speed = 1'b0; cycles(6);
    chk("bounce_hz", hz, 1'b0);
    btn_speed = 1'b1; cycles(10);
    chk("held_hz", hz, 1'b1);
    btn_speed = 1'b0; cycles(10);

    // 4: release bounce during HELD
    btn_dir = 1'b1; cycles(10);
    btn_dir = 1'b0; cycles(2);
    btn_dir = 1'b1; cycles(8);
    btn_dir = 1'b0; cycles(12);

    // 5: simultaneous presses, twice
    for (int r = 0; r < 2; r++) begin
      btn_dir = 1'b1; btn_speed = 1'b1; cycles(10);
      btn_dir = 1'b0; btn_speed = 1'b0; cycles(10);
    end

    // 6: reset mid press-check, then full latency from deassertion
    btn_dir = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 all_zero("reset_async");
    @(negedge clk);
    cycles(2);
    rst = 1'b1;
    latency_check("post_reset_latency");
    cycles(3);
    btn_dir = 1'b0;
    cycles(10);

    // Random segments of held values on both buttons
    for (int s = 0; s < 60; s++) begin
      btn_dir   = 1'($urandom);
      btn_speed = 1'($urandom);
      cycles(($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(1, 7)));
    end
    btn_dir = 1'b0; btn_speed = 1'b0;
    cycles(15);
    chk("dir_q_drained", 1'(dir_q.size() == 0), 1'b1);
    chk("speed_q_drained", 1'(speed_q.size() == 0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
